// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULT_RUN = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DONE     = 2'd3
  } md_state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear, counts while enabled, flags the last step.
module multdiv_counter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_last
);

  logic [CNT_W-1:0] r_count;

  // Count iterations; a new operation restarts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_seq.sv
// Multi-cycle signed multiplier (radix-2 Booth) / divider (restoring), one step per clock.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  md_state_t        r_state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH-1:0] r_m;
  logic             r_sign;
  logic             r_dovf;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic             w_start_mul;
  logic             w_start_div;
  logic             w_run;
  logic             w_last;
  logic             w_b_zero;
  logic             w_min_neg1;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_macc_n;
  logic [WIDTH-1:0] w_mq_n;
  logic             w_mqm1_n;
  logic [WIDTH:0]   w_mul_hi;
  logic             w_mul_exc;
  logic [WIDTH:0]   w_dshift;
  logic [WIDTH:0]   w_ddiff;
  logic [WIDTH:0]   w_dacc_n;
  logic [WIDTH-1:0] w_dq_n;
  logic [WIDTH-1:0] w_div_res;

  // Multiply has priority when both start strobes arrive together.
  assign w_start_mul = ctrl_MULT;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_run       = (r_state == ST_MULT_RUN) || (r_state == ST_DIV_RUN);

  assign w_b_zero   = (data_operandB == '0);
  assign w_min_neg1 = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
  assign w_abs_a    = data_operandA[WIDTH-1] ? (WIDTH'(0) - data_operandA) : data_operandA;
  assign w_abs_b    = data_operandB[WIDTH-1] ? (WIDTH'(0) - data_operandB) : data_operandB;

  multdiv_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_start_mul | w_start_div),
    .i_enable (w_run),
    .o_last   (w_last)
  );

  // Booth step: add/subtract the multiplicand per bit pair, then arithmetic shift right.
  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    w_sum   = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
    {w_macc_n, w_mq_n, w_mqm1_n} = {w_sum[WIDTH], w_sum, r_q};
    w_mul_hi  = {w_macc_n[WIDTH-1:0], w_mq_n[WIDTH-1]};
    w_mul_exc = ~((&w_mul_hi) | ~(|w_mul_hi));
  end

  // Restoring step on magnitudes; quotient bits shift in from the right.
  always_comb begin
    w_dshift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_ddiff  = w_dshift - {1'b0, r_m};
    if (w_ddiff[WIDTH]) begin
      w_dacc_n = w_dshift;
      w_dq_n   = {r_q[WIDTH-2:0], 1'b0};
    end else begin
      w_dacc_n = w_ddiff;
      w_dq_n   = {r_q[WIDTH-2:0], 1'b1};
    end
    w_div_res = r_dovf ? '0 : (r_sign ? (WIDTH'(0) - w_dq_n) : w_dq_n);
  end

  // Control FSM and datapath registers; outputs update only on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_m      <= '0;
      r_sign   <= 1'b0;
      r_dovf   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else if (w_start_mul) begin
      r_state <= ST_MULT_RUN;
      r_acc   <= '0;
      r_q     <= data_operandB;
      r_qm1   <= 1'b0;
      r_m     <= data_operandA;
      r_rdy   <= 1'b0;
    end else if (w_start_div) begin
      r_acc  <= '0;
      r_q    <= w_abs_a;
      r_m    <= w_abs_b;
      r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_dovf <= w_min_neg1;
      if (w_b_zero) begin
        r_state  <= ST_DONE;
        r_result <= '0;
        r_exc    <= 1'b1;
        r_rdy    <= 1'b1;
      end else begin
        r_state <= ST_DIV_RUN;
        r_rdy   <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_MULT_RUN: begin
          r_acc <= w_macc_n;
          r_q   <= w_mq_n;
          r_qm1 <= w_mqm1_n;
          if (w_last) begin
            r_state  <= ST_DONE;
            r_result <= w_mq_n;
            r_exc    <= w_mul_exc;
            r_rdy    <= 1'b1;
          end
        end
        ST_DIV_RUN: begin
          r_acc <= w_dacc_n;
          r_q   <= w_dq_n;
          if (w_last) begin
            r_state  <= ST_DONE;
            r_result <= w_div_res;
            r_exc    <= r_dovf;
            r_rdy    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq.
module tb_multdiv_seq;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_checks;
  int n_errors;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // op: 0 = multiply, 1 = divide, 2 = both strobes high
  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue a one-cycle start pulse; return the cycle (start = 0) of the first RDY, or -1.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        output int rdy_cyc);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = (op != 1);
    ctrl_DIV  = (op != 0);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    rdy_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clock);
      if (data_resultRDY) begin
        rdy_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int first_rdy;
    int rdy_seen;

    n_checks = 0;
    n_errors = 0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;

    vecs[0]  = '{0, 32'd7,         32'hFFFFFFFD, 33, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{0, 32'h00010000,  32'h00010000, 33, 32'h00000000, 1'b1};
    vecs[2]  = '{1, 32'hFFFFFF9C,  32'd7,        33, 32'hFFFFFFF2, 1'b0};
    vecs[3]  = '{1, 32'd100,       32'hFFFFFFF9, 33, 32'hFFFFFFF2, 1'b0};
    vecs[4]  = '{1, 32'd5,         32'd0,        1,  32'h00000000, 1'b1};
    vecs[5]  = '{1, 32'h80000000,  32'hFFFFFFFF, 33, 32'h00000000, 1'b1};
    vecs[6]  = '{2, 32'd6,         32'd2,        33, 32'd12,       1'b0};
    vecs[7]  = '{0, 32'h80000000,  32'd1,        33, 32'h80000000, 1'b0};
    vecs[8]  = '{0, 32'h80000000,  32'h80000000, 33, 32'h00000000, 1'b1};
    vecs[9]  = '{0, 32'h7FFFFFFF,  32'hFFFFFFFF, 33, 32'h80000001, 1'b0};
    vecs[10] = '{0, 32'h00010000,  32'h00008000, 33, 32'h80000000, 1'b1};
    vecs[11] = '{1, 32'h80000000,  32'd1,        33, 32'h80000000, 1'b0};
    vecs[12] = '{1, 32'd3,         32'd5,        33, 32'h00000000, 1'b0};
    vecs[13] = '{1, 32'hFFFFFFF9,  32'd2,        33, 32'hFFFFFFFD, 1'b0};
    vecs[14] = '{1, 32'hFFFFFFFF,  32'h80000000, 33, 32'h00000000, 1'b0};
    vecs[15] = '{1, 32'h7FFFFFFF,  32'd1,        33, 32'h7FFFFFFF, 1'b0};
    vecs[16] = '{0, 32'd12345,     32'd0,        33, 32'h00000000, 1'b0};
    vecs[17] = '{1, 32'hFFFFFFF8,  32'hFFFFFFFE, 33, 32'd4,        1'b0};

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc", {31'b0, data_exception}, 32'h0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b0;

    // Table of single operations
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("v%0d_rdy_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("v%0d_result", i), data_result, vecs[i].res);
      chk($sformatf("v%0d_exc", i), {31'b0, data_exception}, {31'b0, vecs[i].exc});
      @(negedge clock);
      chk($sformatf("v%0d_rdy_pulse", i), {31'b0, data_resultRDY}, 32'h0);
      chk($sformatf("v%0d_hold", i), data_result, vecs[i].res);
    end

    // Abort: MULT 3x4 at cycle 0, DIV 20/4 at cycle 10 -> single RDY at cycle 43
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    first_rdy = -1;
    rdy_seen  = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (data_resultRDY) begin
        rdy_seen++;
        if (first_rdy < 0) begin
          first_rdy = c;
          chk("abort_result", data_result, 32'd5);
          chk("abort_exc", {31'b0, data_exception}, 32'h0);
        end
      end
      if (c == 10) begin
        data_operandA = 32'd20;
        data_operandB = 32'd4;
        ctrl_DIV = 1'b1;
      end
    end
    chk("abort_rdy_cycle", 32'(first_rdy), 32'd43);
    chk("abort_rdy_count", 32'(rdy_seen), 32'd1);

    // Start during DONE: divide-by-zero completes in cycle 1 while a MULT 6x7 begins
    @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd0;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    chk("done_start_rdy1", {31'b0, data_resultRDY}, 32'h1);
    chk("done_start_res1", data_result, 32'h0);
    chk("done_start_exc1", {31'b0, data_exception}, 32'h1);
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    first_rdy = -1;
    for (int c = 2; c <= 45; c++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      if (data_resultRDY && first_rdy < 0) begin
        first_rdy = c;
        chk("done_start_res2", data_result, 32'd42);
        chk("done_start_exc2", {31'b0, data_exception}, 32'h0);
      end
    end
    chk("done_start_rdy2_cycle", 32'(first_rdy), 32'd34);

    // Reset in cycle 15 of a MULT: outputs clear without a clock edge, no RDY afterwards
    @(negedge clock);
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset_result", data_result, 32'h0);
    chk("midreset_exc", {31'b0, data_exception}, 32'h0);
    chk("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    chk("midreset_no_rdy", 32'(rdy_seen), 32'd0);

    // Fresh operation after reset
    run_op(0, 32'hFFFFFFFE, 32'hFFFFFFFE, cyc);
    chk("post_reset_cycle", 32'(cyc), 32'd33);
    chk("post_reset_result", data_result, 32'd4);
    chk("post_reset_exc", {31'b0, data_exception}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
